// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES datapath constants
package aes_pkg;

  localparam int AES_BLOCK_W          = 128;
  localparam int AES_STAGE_FIFO_DEPTH = 4;

endpackage

// File: rtl/aes_fifo_mem.sv
// rtl/aes_fifo_mem.sv - DEPTH x WIDTH register file, synchronous write, asynchronous read
// Optional parity column under AES_STAGE_FIFO_PARITY_EN.
module aes_fifo_mem
  import aes_pkg::*;
#(
  parameter int WIDTH = AES_BLOCK_W,
  parameter int DEPTH = AES_STAGE_FIFO_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
`ifdef AES_STAGE_FIFO_PARITY_EN
  input  logic             wr_par,
  output logic             rd_par,
`endif
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

`ifdef AES_STAGE_FIFO_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) par_mem[wr_addr] <= wr_par;
  end

  assign rd_par = par_mem[rd_addr];
`endif

endmodule

// File: rtl/aes_stage_fifo.sv
// rtl/aes_stage_fifo.sv - first-word fall-through stage FIFO with enable, flush and sticky parity error
// Parity storage and checking enabled by AES_STAGE_FIFO_PARITY_EN.
module aes_stage_fifo
  import aes_pkg::*;
#(
  parameter int WIDTH = AES_BLOCK_W,
  parameter int DEPTH = AES_STAGE_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     clear_i,
  input  logic                     enable_i,
  input  logic [WIDTH-1:0]         d_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic [WIDTH-1:0]         d_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     par_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rd_data;
  logic             push, pop;

  assign full_o  = (count == CW'(DEPTH));
  assign empty_o = (count == '0);
  assign ready_o = enable_i && !full_o;
  assign valid_o = enable_i && !empty_o;
  assign push    = valid_i && ready_o;
  assign pop     = valid_o && ready_i;
  assign count_o = count;
  // Stale storage stays behind after a flush, so the head is masked while empty.
  assign d_o     = empty_o ? '0 : rd_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef AES_STAGE_FIFO_PARITY_EN
  logic rd_par;
  logic par_err;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                        par_err <= 1'b0;
    else if (clear_i)                   par_err <= 1'b0;
    else if (pop && ((^rd_data) != rd_par)) par_err <= 1'b1;
  end

  assign par_err_o = par_err;
`else
  assign par_err_o = 1'b0;
`endif

  aes_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push && !clear_i),
    .wr_addr (wr_ptr),
    .wr_data (d_i),
`ifdef AES_STAGE_FIFO_PARITY_EN
    .wr_par  (^d_i),
    .rd_par  (rd_par),
`endif
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_aes_stage_fifo.sv
// tb/tb_aes_stage_fifo.sv - self-checking bench for aes_stage_fifo against a queue model
// Parity scenario compiled only with AES_STAGE_FIFO_PARITY_EN.
module tb_aes_stage_fifo;

  localparam int W = 128;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         resetn;
  logic         clear_i, enable_i, valid_i, ready_i;
  logic [W-1:0] d_i;
  logic         ready_o, valid_o, full_o, empty_o, par_err_o;
  logic [W-1:0] d_o;
  logic [2:0]   count_o;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] model_q[$];
  logic [W-1:0] got_q[$];
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  aes_stage_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .clear_i   (clear_i),
    .enable_i  (enable_i),
    .d_i       (d_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .d_o       (d_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .count_o   (count_o),
    .full_o    (full_o),
    .empty_o   (empty_o),
    .par_err_o (par_err_o)
  );

  function automatic logic [W-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [W-1:0] model_head();
    return (model_q.size() == 0) ? '0 : model_q[0];
  endfunction

  // Drive one cycle from a negedge; model transfers follow the handshake rules on pre-edge occupancy.
  task automatic cycle(input logic en, input logic vi, input logic ri, input logic cl,
                       input logic [W-1:0] d);
    logic do_push, do_pop;
    enable_i = en; valid_i = vi; ready_i = ri; clear_i = cl; d_i = d;
    #1;
    do_push = vi && en && (model_q.size() < D);
    do_pop  = ri && en && (model_q.size() > 0);
    if (do_pop && !cl) got_q.push_back(d_o);
    @(posedge clk);
    if (cl) model_q.delete();
    else begin
      if (do_pop)  exp_q.push_back(model_q.pop_front());
      if (do_push) model_q.push_back(d);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    tests++;
    if (count_o !== 3'd0 || empty_o !== 1'b1 || full_o !== 1'b0 || valid_o !== 1'b0 ||
        d_o !== '0 || par_err_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: count=%0d empty=%b full=%b valid=%b d=%h perr=%b required 0 1 0 0 0 0",
               count_o, empty_o, full_o, valid_o, d_o, par_err_o);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) begin
        enable_i = 1'b1; valid_i = 1'b1; ready_i = 1'b0; clear_i = 1'b0; #1;
        tests++;
        if (ready_o !== 1'b0) begin
          fails++; $display("FAIL fill_ready_fifth: ready_o=%b required 0", ready_o);
        end
      end
      cycle(1'b1, 1'b1, 1'b0, 1'b0, W'(i));
    end
    tests++;
    if (count_o !== 3'd4 || full_o !== 1'b1 || d_o !== W'(1)) begin
      fails++; $display("FAIL fill_full: count=%0d full=%b head=%h required 4 1 1", count_o, full_o, d_o);
    end
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (got_q[i] !== W'(i + 1)) begin
        fails++; $display("FAIL fill_pop_order[%0d]: got %h required %h", i, got_q[i], W'(i + 1));
      end
    end
    tests++;
    if (empty_o !== 1'b1 || count_o !== 3'd0 || d_o !== '0) begin
      fails++; $display("FAIL fill_drained: empty=%b count=%0d d=%h required 1 0 0", empty_o, count_o, d_o);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_streaming();
    cycle(1'b1, 1'b1, 1'b0, 1'b0, rnd_word());
    cycle(1'b1, 1'b1, 1'b0, 1'b0, rnd_word());
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, rnd_word());
      tests++;
      if (count_o !== 3'd2) begin
        fails++; $display("FAIL stream_count[%0d]: count=%0d required 2", i, count_o);
      end
    end
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL stream_order[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_freeze();
    cycle(1'b1, 1'b1, 1'b0, 1'b0, rnd_word());
    tests++;
    if (count_o !== 3'd3) begin
      fails++; $display("FAIL freeze_setup: count=%0d required 3", count_o);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0, rnd_word());
      tests++;
      if (count_o !== 3'd3 || valid_o !== 1'b0 || ready_o !== 1'b0) begin
        fails++; $display("FAIL freeze[%0d]: count=%0d valid=%b ready=%b required 3 0 0",
                          i, count_o, valid_o, ready_o);
      end
    end
    tests++;
    if (got_q.size() != 0) begin
      fails++; $display("FAIL freeze_no_pop: pops=%0d required 0", got_q.size());
    end
  endtask

  task automatic test_clear();
    cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
    tests++;
    if (count_o !== 3'd2) begin
      fails++; $display("FAIL clear_setup: count=%0d required 2", count_o);
    end
    cycle(1'b1, 1'b1, 1'b0, 1'b1, W'(32'hA));
    tests++;
    if (count_o !== 3'd0 || d_o !== '0 || empty_o !== 1'b1) begin
      fails++; $display("FAIL clear_flush: count=%0d d=%h empty=%b required 0 0 1", count_o, d_o, empty_o);
    end
    cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
    tests++;
    if (valid_o !== 1'b0 || count_o !== 3'd0) begin
      fails++; $display("FAIL clear_not_stored: valid=%b count=%0d required 0 0", valid_o, count_o);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 1'b1, 1'b0, 1'b0, rnd_word());
    cycle(1'b1, 1'b1, 1'b0, 1'b0, rnd_word());
    enable_i = 1'b1; valid_i = 1'b1; ready_i = 1'b1; d_i = rnd_word();
    #2 resetn = 1'b0;
    #1;
    model_q.delete();
    tests++;
    if (count_o !== 3'd0 || empty_o !== 1'b1 || full_o !== 1'b0 || valid_o !== 1'b0 ||
        d_o !== '0 || par_err_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_async: count=%0d empty=%b full=%b valid=%b d=%h perr=%b required 0 1 0 0 0 0",
               count_o, empty_o, full_o, valid_o, d_o, par_err_o);
    end
    @(negedge clk);
    resetn = 1'b1;
    cycle(1'b1, 1'b1, 1'b0, 1'b0, W'(32'hB));
    tests++;
    if (d_o !== W'(32'hB) || valid_o !== 1'b1 || count_o !== 3'd1) begin
      fails++; $display("FAIL reset_first_push: d=%h valid=%b count=%0d required b 1 1", d_o, valid_o, count_o);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b1, '0);
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) != 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 49) == 0), rnd_word());
      tests++;
      if (count_o !== 3'(model_q.size()) || d_o !== model_head() ||
          full_o !== (model_q.size() == D) || empty_o !== (model_q.size() == 0) ||
          valid_o !== (enable_i && model_q.size() != 0) ||
          ready_o !== (enable_i && model_q.size() != D) || par_err_o !== 1'b0) begin
        fails++;
        $display("FAIL random[%0d]: count=%0d d=%h full=%b empty=%b valid=%b ready=%b perr=%b required count=%0d d=%h",
                 i, count_o, d_o, full_o, empty_o, valid_o, ready_o, par_err_o, model_q.size(), model_head());
      end
    end
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL random_pop_count: got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL random_pop[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

`ifdef AES_STAGE_FIFO_PARITY_EN
  task automatic test_parity();
    cycle(1'b1, 1'b0, 1'b0, 1'b1, '0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, rnd_word());
    cycle(1'b1, 1'b1, 1'b0, 1'b0, rnd_word());
    dut.u_mem.mem[0][7] = ~dut.u_mem.mem[0][7];
    cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
    tests++;
    if (par_err_o !== 1'b1) begin
      fails++; $display("FAIL parity_set: par_err=%b required 1", par_err_o);
    end
    cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    tests++;
    if (par_err_o !== 1'b1) begin
      fails++; $display("FAIL parity_hold: par_err=%b required 1", par_err_o);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b1, '0);
    tests++;
    if (par_err_o !== 1'b0) begin
      fails++; $display("FAIL parity_clear: par_err=%b required 0", par_err_o);
    end
    got_q.delete(); exp_q.delete();
  endtask
`endif

  initial begin
    resetn = 1'b0; clear_i = 1'b0; enable_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; d_i = '0;
    repeat (2) @(negedge clk);
    test_reset();
    resetn = 1'b1;
    @(negedge clk);
    test_fill();
    test_streaming();
    test_freeze();
    test_clear();
    test_reset_mid();
    test_random();
`ifdef AES_STAGE_FIFO_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_stage_fifo.md
AES_STAGE_FIFO -- requirements
Module: aes_stage_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 128, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, entry count; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port resetn  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port clear_i  input  1  synchronous flush.
REQ-006 SHALL have port enable_i  input  1  global advance enable; low freezes all transfers.
REQ-007 SHALL have port d_i  input  WIDTH  write data.
REQ-008 SHALL have port valid_i  input  1  write valid.
REQ-009 SHALL have port ready_o  output  1  write ready.
REQ-010 SHALL have port d_o  output  WIDTH  head-of-queue data.
REQ-011 SHALL have port valid_o  output  1  read valid.
REQ-012 SHALL have port ready_i  input  1  read ready.
REQ-013 SHALL have port count_o  output  $clog2(DEPTH)+1  occupancy.
REQ-014 SHALL have ports full_o and empty_o  output  1 each  occupancy flags.
REQ-015 SHALL have port par_err_o  output  1  sticky parity error.

Function
REQ-016 Push SHALL occur when valid_i && ready_o; pop SHALL occur when valid_o && ready_i.
REQ-017 ready_o SHALL equal enable_i && !full_o; valid_o SHALL equal enable_i && !empty_o.
REQ-018 The queue SHALL be first-word fall-through: an entry pushed at edge N SHALL appear on d_o with valid_o high in cycle N+1.
REQ-019 d_o SHALL present the oldest entry and SHALL read all-zero while empty_o is high.
REQ-020 A simultaneous push and pop SHALL leave count_o unchanged and preserve order.
REQ-021 full_o SHALL be high iff count_o == DEPTH; empty_o SHALL be high iff count_o == 0.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH with no lost or duplicated entries.
REQ-023 While enable_i is low, contents, pointers and count SHALL hold regardless of valid_i and ready_i.
REQ-024 clear_i SHALL take priority over push and pop: at the next edge, count becomes 0, pointers become 0 and par_err_o clears.
REQ-025 Storage contents need not be zeroed by clear_i, since REQ-019 masks d_o.

Reset
REQ-026 While resetn is low: count_o = 0, empty_o = 1, full_o = 0, valid_o = 0, d_o = 0, par_err_o = 0, pointers = 0.
REQ-027 Reset asserted mid-operation SHALL discard all entries immediately, independent of clk.

Configuration
REQ-028 With macro AES_STAGE_FIFO_PARITY_EN defined, each entry SHALL store an even-parity bit computed on push.
REQ-029 With AES_STAGE_FIFO_PARITY_EN defined, a pop whose recomputed parity mismatches SHALL set par_err_o at the next edge; par_err_o SHALL hold until clear_i or reset.
REQ-030 Without AES_STAGE_FIFO_PARITY_EN, no parity storage SHALL exist and par_err_o SHALL be tied to 0.

Structure
REQ-031 Package aes_pkg SHALL hold AES_BLOCK_W = 128 and AES_STAGE_FIFO_DEPTH = 4, used as the parameter defaults.
REQ-032 Storage SHALL be the sub-module aes_fifo_mem (DEPTH x WIDTH plus optional parity column, synchronous write, asynchronous read); pointer, count and flag logic SHALL stay in aes_stage_fifo.

Verification
REQ-033 Fill test: enable_i = 1, ready_i = 0, push 0x1..0x5 on consecutive cycles -> 0x1..0x4 accepted, count_o = 4, full_o = 1, ready_o = 0 on the fifth; then ready_i = 1 -> pops 0x1..0x4 in order, empty_o = 1.
REQ-034 Streaming test: continuous push/pop for 10 cycles at count_o = 2 -> count_o stays 2, output order equals input order, pointers wrap twice.
REQ-035 Freeze test: enable_i = 0 for 3 cycles with valid_i = ready_i = 1 and count_o = 3 -> no transfer, count_o = 3, valid_o = 0, ready_o = 0.
REQ-036 Clear test: clear_i = 1 with a simultaneous push of 0xA at count_o = 2 -> count_o = 0 next cycle, d_o = 0, 0xA not stored.
REQ-037 Reset test: resetn low mid-burst between edges -> all outputs at REQ-026 values immediately; after release, first push of 0xB appears on d_o one cycle later.
REQ-038 Parity test (AES_STAGE_FIFO_PARITY_EN defined): force a bit flip in a stored entry, then pop it -> par_err_o = 1 and holds until clear_i.
